gyro_frame_scheduler: RTL and testbench
=======================================

# gyro_frame_scheduler

Per-frame controller that sits between the gyroscope processing path and the renderer. Once per video frame it captures the latest pitch/roll/yaw sample and subtracts a user-settable zero offset, then issues a single start pulse to the renderer. It tracks the render to completion and counts overrun frames and stale samples. This keeps the pose constant across a rendered frame and decouples the asynchronous gyro sample rate from the frame rate.

## Interface
Parameters:
- SAMPLE_TIMEOUT, 1024: maximum cycles spent in WAIT_SAMPLE before the previous pose is reused; must be at least 1.
- COUNT_WIDTH, 8: width of the saturating diagnostic counters.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_in  input  1  asynchronous, active-high reset.
- en_in  input  1  when low, new frames are not accepted from IDLE.
- new_frame_in  input  1  one-cycle frame-start pulse from the video timing generator.
- gyro_valid_in  input  1  one-cycle pulse; pitch_in/roll_in/yaw_in are valid.
- pitch_in, roll_in, yaw_in  input  16 each  signed orientation sample.
- zero_in  input  1  one-cycle pulse; captures the current orientation as the zero offset.
- render_done_in  input  1  one-cycle pulse from the renderer when the frame is finished.
- render_start_out  output  1  one-cycle start pulse to the renderer.
- pitch_out, roll_out, yaw_out  output  16 each  offset-corrected pose, held for the whole frame.
- busy_out  output  1  high whenever state is not IDLE.
- drop_count_out  output  COUNT_WIDTH  frames dropped because of overrun (saturating).
- stale_count_out  output  COUNT_WIDTH  frames rendered with a reused pose (saturating).

## Operation
- Latest-sample register (L): loads pitch_in/roll_in/yaw_in on every gyro_valid_in pulse, in any state. Sets the fresh flag.
- Offset register (O): on zero_in, loads the incoming sample if gyro_valid_in is high in the same cycle, otherwise loads L.
- Pose arithmetic: pose = sample − O, per axis, 16-bit two's complement, wrapping modulo 2^16 with no saturation.
- States:
  - IDLE: on new_frame_in with en_in high, go to WAIT_SAMPLE and clear the timeout counter. If en_in is low, ignore the pulse; it is not counted.
  - WAIT_SAMPLE (source selection):
    - If gyro_valid_in is high this cycle, use the incoming sample (bypass).
    - Otherwise, if fresh is set, use L.
    - In either case, register pose = sample − O, clear fresh, and go to START.
    - Otherwise, if the counter equals SAMPLE_TIMEOUT−1, hold the pose, increment stale_count, and go to START.
    - Otherwise, increment the counter.
  - START: render_start_out is high for exactly this one cycle. Go to RENDER.
  - RENDER: on render_done_in, go to IDLE. render_done_in in any other state is ignored.
- Overrun: new_frame_in while in WAIT_SAMPLE, START or RENDER increments drop_count (saturating at all-ones). The frame is discarded; the state is unaffected.
- zero_in and a pose latch in the same cycle: the latch uses the old O, and O updates at the same edge.
- en_in going low mid-frame does not abort the frame in progress.

## Timing
- Reset values (immediate, asynchronous):
  - State IDLE.
  - render_start_out = 0, busy_out = 0.
  - pitch/roll/yaw_out = 0.
  - L = 0, O = 0, fresh = 0.
  - Both counters = 0.
- A reset mid-frame aborts with no start pulse.
- Latency when a sample is available:
  - new_frame_in at cycle t: WAIT_SAMPLE at t+1.
  - Pose valid and render_start_out high at t+2.
  - RENDER at t+3.
- Latency on timeout: render_start_out is high at t+1+SAMPLE_TIMEOUT.
- pose_out changes only on the edge that exits WAIT_SAMPLE. It is stable from render_start_out until the next frame.
- busy_out is registered with the state and is high from t+1 through the cycle render_done_in is sampled.
- The first new_frame_in accepted after render_done_in is the one sampled in IDLE; there is no extra gap.

## Test plan
- Reset, then feed sample (100, −50, 7) and then new_frame_in → render_start_out high 2 cycles after new_frame_in; pose_out = (100, −50, 7); busy_out = 1 until render_done_in.
- zero_in with sample (100, −50, 7) in L, then a new sample (90, 0, −32768) and a frame → pose_out = (−10, 50, 32761), confirming wraparound.
- SAMPLE_TIMEOUT=16, no gyro_valid_in after the previous frame → start pulse 17 cycles after new_frame_in; pose_out unchanged; stale_count_out increments by 1.
- 3 new_frame_in pulses during RENDER → drop_count_out = 3 and one start pulse total. With COUNT_WIDTH=2 and 5 overruns → holds at 3.
- gyro_valid_in with (1, 2, 3) in the same cycle as the WAIT_SAMPLE decision, with stale L = (9, 9, 9) → pose_out = (1, 2, 3).
- Assert rst_in during RENDER → all outputs return to zero at once; the next frame starts cleanly. en_in = 0 with new_frame_in → no start pulse and no drop count.

Source files
------------

// File: rtl/gyro_frame_scheduler_if.sv
// Bundle between the gyro/video side and the per-frame scheduler.
// Ports: frame/gyro/zero/render-done inputs; start pulse, pose, busy, counters.
interface gyro_frame_scheduler_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   en_in;
    logic                   new_frame_in;
    logic                   gyro_valid_in;
    logic signed [15:0]     pitch_in;
    logic signed [15:0]     roll_in;
    logic signed [15:0]     yaw_in;
    logic                   zero_in;
    logic                   render_done_in;
    logic                   render_start_out;
    logic signed [15:0]     pitch_out;
    logic signed [15:0]     roll_out;
    logic signed [15:0]     yaw_out;
    logic                   busy_out;
    logic [COUNT_WIDTH-1:0] drop_count_out;
    logic [COUNT_WIDTH-1:0] stale_count_out;

    modport master (
        output en_in, new_frame_in, gyro_valid_in,
        output pitch_in, roll_in, yaw_in,
        output zero_in, render_done_in,
        input  render_start_out, pitch_out, roll_out, yaw_out,
        input  busy_out, drop_count_out, stale_count_out
    );

    modport slave (
        input  en_in, new_frame_in, gyro_valid_in,
        input  pitch_in, roll_in, yaw_in,
        input  zero_in, render_done_in,
        output render_start_out, pitch_out, roll_out, yaw_out,
        output busy_out, drop_count_out, stale_count_out
    );
endinterface

// File: rtl/gyro_frame_scheduler.sv
// Per-frame pose capture: latches offset-corrected gyro pose once per frame,
// pulses render start, tracks the render and counts overruns/stale poses.
// Ports: clk_in, rst_in (async, active high), bus (slave side of the bundle).
module gyro_frame_scheduler #(
    parameter int SAMPLE_TIMEOUT = 1024,
    parameter int COUNT_WIDTH    = 8
) (
    input logic                  clk_in,
    input logic                  rst_in,
    gyro_frame_scheduler_if.slave bus
);
    localparam int TW = (SAMPLE_TIMEOUT > 1) ? $clog2(SAMPLE_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SAMPLE,
        START,
        RENDER
    } state_t;

    state_t state, state_nx;

    logic [TW-1:0]          tmo_cnt;
    logic                   latch, timeout, cnt_clr, cnt_inc;
    logic                   fresh;
    logic signed [15:0]     lat_p, lat_r, lat_y;
    logic signed [15:0]     off_p, off_r, off_y;
    logic signed [15:0]     pose_p, pose_r, pose_y;
    logic signed [15:0]     src_p, src_r, src_y;
    logic [COUNT_WIDTH-1:0] drop_cnt, stale_cnt;

    // An incoming sample in the decision cycle beats the latched one.
    assign src_p = bus.gyro_valid_in ? bus.pitch_in : lat_p;
    assign src_r = bus.gyro_valid_in ? bus.roll_in  : lat_r;
    assign src_y = bus.gyro_valid_in ? bus.yaw_in   : lat_y;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        timeout  = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.new_frame_in && bus.en_in) begin
                    state_nx = WAIT_SAMPLE;
                    cnt_clr  = 1'b1;
                end
            end
            WAIT_SAMPLE: begin
                if (bus.gyro_valid_in || fresh) begin
                    latch    = 1'b1;
                    state_nx = START;
                end else if (tmo_cnt == TW'(SAMPLE_TIMEOUT - 1)) begin
                    timeout  = 1'b1;
                    state_nx = START;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            START: state_nx = RENDER;
            RENDER: begin
                if (bus.render_done_in) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tmo_cnt   <= '0;
            fresh     <= 1'b0;
            lat_p     <= '0;
            lat_r     <= '0;
            lat_y     <= '0;
            off_p     <= '0;
            off_r     <= '0;
            off_y     <= '0;
            pose_p    <= '0;
            pose_r    <= '0;
            pose_y    <= '0;
            drop_cnt  <= '0;
            stale_cnt <= '0;
        end else begin
            if (cnt_clr)      tmo_cnt <= '0;
            else if (cnt_inc) tmo_cnt <= tmo_cnt + TW'(1);

            if (bus.gyro_valid_in) begin
                lat_p <= bus.pitch_in;
                lat_r <= bus.roll_in;
                lat_y <= bus.yaw_in;
            end

            // Consuming a sample wins over a new arrival in the same cycle.
            if (latch)                  fresh <= 1'b0;
            else if (bus.gyro_valid_in) fresh <= 1'b1;

            // Pose uses the old offset when zero_in lands on the latch edge.
            if (bus.zero_in) begin
                off_p <= src_p;
                off_r <= src_r;
                off_y <= src_y;
            end

            if (latch) begin
                pose_p <= src_p - off_p;
                pose_r <= src_r - off_r;
                pose_y <= src_y - off_y;
            end

            if (bus.new_frame_in && state != IDLE && !(&drop_cnt))
                drop_cnt <= drop_cnt + COUNT_WIDTH'(1);

            if (timeout && !(&stale_cnt))
                stale_cnt <= stale_cnt + COUNT_WIDTH'(1);
        end
    end

    assign bus.render_start_out = (state == START);
    assign bus.busy_out         = (state != IDLE);
    assign bus.pitch_out        = pose_p;
    assign bus.roll_out         = pose_r;
    assign bus.yaw_out          = pose_y;
    assign bus.drop_count_out   = drop_cnt;
    assign bus.stale_count_out  = stale_cnt;
endmodule

// File: tb/tb_gyro_frame_scheduler.sv
// Directed bench for gyro_frame_scheduler (SAMPLE_TIMEOUT=16, COUNT_WIDTH=2).
// Ports: none; drives the master side of the interface.
module tb_gyro_frame_scheduler;
    localparam int TMO = 16;
    localparam int CW  = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    gyro_frame_scheduler_if #(.COUNT_WIDTH(CW)) bus ();

    gyro_frame_scheduler #(
        .SAMPLE_TIMEOUT(TMO),
        .COUNT_WIDTH   (CW)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic gyro(input int p, input int r, input int y);
        bus.gyro_valid_in = 1'b1;
        bus.pitch_in      = 16'(p);
        bus.roll_in       = 16'(r);
        bus.yaw_in        = 16'(y);
        tick();
        bus.gyro_valid_in = 1'b0;
    endtask

    task automatic frame();
        bus.new_frame_in = 1'b1;
        tick();
        bus.new_frame_in = 1'b0;
    endtask

    task automatic done();
        bus.render_done_in = 1'b1;
        tick();
        bus.render_done_in = 1'b0;
    endtask

    task automatic chk_pose(input string tag, input int p, input int r,
                            input int y);
        chk({tag, ".pitch"}, int'(bus.pitch_out), p);
        chk({tag, ".roll"},  int'(bus.roll_out),  r);
        chk({tag, ".yaw"},   int'(bus.yaw_out),   y);
    endtask

    initial begin
        int n;
        int starts;

        bus.en_in          = 1'b1;
        bus.new_frame_in   = 1'b0;
        bus.gyro_valid_in  = 1'b0;
        bus.pitch_in       = '0;
        bus.roll_in        = '0;
        bus.yaw_in         = '0;
        bus.zero_in        = 1'b0;
        bus.render_done_in = 1'b0;

        repeat (2) tick();
        chk("rst_busy",  int'(bus.busy_out), 0);
        chk("rst_start", int'(bus.render_start_out), 0);
        chk_pose("rst_pose", 0, 0, 0);
        chk("rst_drop",  int'(bus.drop_count_out), 0);
        chk("rst_stale", int'(bus.stale_count_out), 0);
        rst_in = 1'b0;
        tick();

        // Basic frame with a fresh sample
        gyro(100, -50, 7);
        frame();
        chk("t1_busy_wait", int'(bus.busy_out), 1);
        chk("t1_start_early", int'(bus.render_start_out), 0);
        tick();
        chk("t1_start", int'(bus.render_start_out), 1);
        chk_pose("t1_pose", 100, -50, 7);
        tick();
        chk("t1_start_once", int'(bus.render_start_out), 0);
        chk("t1_busy_render", int'(bus.busy_out), 1);
        done();
        chk("t1_busy_idle", int'(bus.busy_out), 0);

        // Zero from L, then a frame with wraparound on yaw
        bus.zero_in = 1'b1;
        tick();
        bus.zero_in = 1'b0;
        gyro(90, 0, -32768);
        frame();
        tick();
        chk("t2_start", int'(bus.render_start_out), 1);
        chk_pose("t2_pose", -10, 50, 32761);
        tick();
        done();

        // Timeout: no sample since last frame
        frame();
        n = 1;
        while (bus.render_start_out !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t3_latency", n, TMO + 1);
        chk_pose("t3_pose", -10, 50, 32761);
        chk("t3_stale", int'(bus.stale_count_out), 1);
        tick();
        done();

        // Overruns during RENDER, then saturation
        gyro(0, 0, 0);
        frame();
        tick();
        starts = int'(bus.render_start_out);
        tick();
        repeat (3) begin
            frame();
            starts += int'(bus.render_start_out);
            tick();
            starts += int'(bus.render_start_out);
        end
        chk("t4_drop3", int'(bus.drop_count_out), 3);
        chk("t4_one_start", starts, 1);
        repeat (2) frame();
        chk("t4_drop_sat", int'(bus.drop_count_out), 3);
        chk("t4_busy", int'(bus.busy_out), 1);
        done();

        // Bypass of stale L by a same-cycle sample
        bus.zero_in = 1'b1;
        gyro(0, 0, 0);
        bus.zero_in = 1'b0;
        gyro(9, 9, 9);
        frame();
        tick();
        chk_pose("t5_l9", 9, 9, 9);
        tick();
        done();
        frame();
        bus.gyro_valid_in = 1'b1;
        bus.pitch_in      = 16'(1);
        bus.roll_in       = 16'(2);
        bus.yaw_in        = 16'(3);
        tick();
        bus.gyro_valid_in = 1'b0;
        chk("t5_start", int'(bus.render_start_out), 1);
        chk_pose("t5_bypass", 1, 2, 3);
        tick();
        done();

        // Asynchronous reset in RENDER
        gyro(5, 5, 5);
        frame();
        tick();
        tick();
        chk("t6_in_render", int'(bus.busy_out), 1);
        rst_in = 1'b1;
        #1;
        chk("t6_rst_busy", int'(bus.busy_out), 0);
        chk("t6_rst_start", int'(bus.render_start_out), 0);
        chk_pose("t6_rst_pose", 0, 0, 0);
        chk("t6_rst_drop", int'(bus.drop_count_out), 0);
        chk("t6_rst_stale", int'(bus.stale_count_out), 0);
        tick();
        rst_in = 1'b0;
        tick();
        gyro(4, -4, 0);
        frame();
        tick();
        chk("t6_restart", int'(bus.render_start_out), 1);
        chk_pose("t6_pose", 4, -4, 0);
        tick();
        done();

        // Disabled: frame ignored and not counted
        bus.en_in = 1'b0;
        frame();
        starts = 0;
        repeat (20) begin
            starts += int'(bus.render_start_out);
            tick();
        end
        chk("t7_no_start", starts, 0);
        chk("t7_busy", int'(bus.busy_out), 0);
        chk("t7_drop", int'(bus.drop_count_out), 0);
        bus.en_in = 1'b1;

        // en_in dropping mid-frame does not abort
        gyro(1, 1, 1);
        frame();
        bus.en_in = 1'b0;
        tick();
        chk("t8_start", int'(bus.render_start_out), 1);
        tick();
        done();
        bus.en_in = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
